bus_bridge: RTL and testbench
=============================

# bus_bridge

Bus bridge between the single-cycle core's data port and the data memory plus on-board I/O. Decodes each CPU bus access by address and routes it to the DRAM or to one of the memory-mapped peripherals. The peripherals are LED register, switches, buttons, a 32-bit cycle timer and an 8-digit seven-segment scanner. Reads are combinational, for the core's single-cycle loads; writes commit on the rising clock edge.

## Interface
- SCAN_DIV, 50000, clock cycles each seven-segment digit stays lit (≥2)
- DRAM_AW, 14, DRAM word-address width
- cpu_clk  in  1  system clock, all state on rising edge
- cpu_rst  in  1  reset; asynchronous, active-low
- Bus_addr  in  32  byte address from core
- Bus_we  in  4  byte-lane write enables (bit i ↔ Bus_wdata[8i+7:8i]); 0 = read/no access
- Bus_wdata  in  32  write data, already lane-replicated by core
- Bus_rdata  out  32  read data to core
- dram_addr  out  DRAM_AW  = Bus_addr[DRAM_AW+1:2]
- dram_we  out  4  Bus_we gated by DRAM hit
- dram_wdata  out  32  = Bus_wdata
- dram_rdata  in  32  DRAM asynchronous read data
- sw  in  24  raw switches (asynchronous)
- btn  in  5  raw buttons (asynchronous)
- led  out  24  LED register
- dig_en  out  8  digit enables, active-low, one-cold
- dig_seg  out  8  segments {dp,g,f,e,d,c,b,a}, active-high

## Operation
- Address map (full 32-bit compare for I/O):
  - DRAM: Bus_addr < 0xFFFF_F000.
  - DIG 0xFFFF_F000 (R/W, 32-bit, eight hex nibbles; nibble k → digit k).
  - TIMER 0xFFFF_F020 (R/W).
  - LED 0xFFFF_F060 (R/W, bits 23:0; 31:24 read 0).
  - SW 0xFFFF_F070 (R, bits 23:0).
  - BTN 0xFFFF_F078 (R, bits 4:0).
  - Any other address ≥0xFFFF_F000 reads 0; writes to it are ignored.
- Bus_rdata: pure mux by address. DRAM hit → dram_rdata; I/O → register value as it stands before the current edge.
- DIG, LED writes: per byte lane, only lanes with Bus_we[i]=1 update. LED lane 3 is discarded.
- SW, BTN: two-flop synchronizers. Reads return the synchronized value. Writes are ignored.
- TIMER: free-running 32-bit up-counter, +1 per cycle, wraps 0xFFFF_FFFF→0.
  - Write with Bus_we=4'b1111 loads Bus_wdata; the load takes priority over the increment on that edge.
  - Partial-lane writes are ignored; the counter still increments.
- dram_we = Bus_we when DRAM hit, else 0. DRAM range writes never touch I/O registers.
- Scanner: counter scan_cnt 0..SCAN_DIV-1 and digit index idx 0..7.
  - When scan_cnt = SCAN_DIV-1: scan_cnt→0 and idx→idx+1 mod 8 (7→0).
  - dig_en = ~(8'b1 << idx).
  - dig_seg = hex decode of DIG[4idx+3:4idx]:
    - 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07
    - 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71
  - dp always 0.

## Timing
- Reset (cpu_rst=0, asynchronous, any time):
  - DIG=0, LED=0, TIMER=0, scan_cnt=0, idx=0, synchronizers=0.
  - Outputs: led=0, dig_en=8'hFE, dig_seg=8'h3F, Bus_rdata per mux of reset values / dram_rdata.
  - While held in reset, nothing updates regardless of Bus_we.
  - Release: first rising edge with cpu_rst=1 performs normal update. TIMER reads 1 after that edge.
- Write latency: a register written at edge N is visible on Bus_rdata, led, dig_seg from edge N onward (same cycle after edge).
- Read latency: zero cycles, combinational. TIMER read in cycle N returns its value during cycle N.
- sw/btn latency: a change is visible in reads 2 edges later.
- Digit dwell: exactly SCAN_DIV cycles per digit. Full scan period is 8·SCAN_DIV cycles.
- Simultaneous DIG write and digit advance on the same edge: the new idx displays the new DIG nibble immediately.

## Test plan
- Reset/defaults: hold cpu_rst=0 mid-run with Bus_we=4'hF at LED.
  - Expect led=0, dig_en=8'hFE, dig_seg=8'h3F, TIMER read 0.
  - Release; after 5 edges, TIMER reads 5.
- DRAM routing:
  - Write 0xDEADBEEF, Bus_we=4'hF, addr 0x0000_0104 → dram_we=4'hF, dram_addr=0x41, led unchanged.
  - Write to 0xFFFF_F060 → dram_we=0.
- Byte lanes: LED write 0x00AB_CDEF we=4'hF, then 0x0012_3412 with we=4'b0100.
  - Expect led=0x12CDEF; LED read returns 0x0012_CDEF.
- Timer load/wrap:
  - Full write 0xFFFF_FFFE → reads 0xFFFF_FFFE, 0xFFFF_FFFF, then 0x0000_0000 on consecutive cycles.
  - Partial write we=4'b0001 → no load.
- Scanner (SCAN_DIV=4): DIG=0x8765_43A1.
  - Expect dig_en 8'hFE/dig_seg 8'h06 for 4 cycles, then 8'hFD/8'h77, then 8'hFB/8'h4F, ...
  - After 32 cycles, back to 8'hFE.
- Inputs and unmapped:
  - sw=0x5A5A5A → SW read 0x005A_5A5A two edges later.
  - btn=5'b10011 → BTN read 0x13.
  - Read 0xFFFF_F040 → 0; a write there changes nothing.

Source files
------------

// File: rtl/bus_bridge.sv
// Data-bus bridge: routes core loads/stores to DRAM or on-board I/O
// (LED, switches, buttons, cycle timer, seven-segment scanner).
module bus_bridge #(
    parameter int SCAN_DIV = 50000,
    parameter int DRAM_AW  = 14
) (
    input  logic               cpu_clk,
    input  logic               cpu_rst,
    input  logic [31:0]        Bus_addr,
    input  logic [3:0]         Bus_we,
    input  logic [31:0]        Bus_wdata,
    output logic [31:0]        Bus_rdata,
    output logic [DRAM_AW-1:0] dram_addr,
    output logic [3:0]         dram_we,
    output logic [31:0]        dram_wdata,
    input  logic [31:0]        dram_rdata,
    input  logic [23:0]        sw,
    input  logic [4:0]         btn,
    output logic [23:0]        led,
    output logic [7:0]         dig_en,
    output logic [7:0]         dig_seg
);

    localparam int SCW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SCW-1:0] SCAN_LAST = SCW'(SCAN_DIV - 1);

    localparam logic [31:0] IO_BASE = 32'hFFFF_F000;
    localparam logic [31:0] A_DIG   = 32'hFFFF_F000;
    localparam logic [31:0] A_TMR   = 32'hFFFF_F020;
    localparam logic [31:0] A_LED   = 32'hFFFF_F060;
    localparam logic [31:0] A_SW    = 32'hFFFF_F070;
    localparam logic [31:0] A_BTN   = 32'hFFFF_F078;

    logic [31:0]    dig_q, dig_d;
    logic [23:0]    led_q, led_d;
    logic [31:0]    tmr_q, tmr_d;
    logic [SCW-1:0] scan_q, scan_d;
    logic [2:0]     idx_q, idx_d;
    logic [23:0]    sw1_q, sw1_d, sw2_q, sw2_d;
    logic [4:0]     btn1_q, btn1_d, btn2_q, btn2_d;

    logic io_hit, sel_dig, sel_tmr, sel_led, sel_sw, sel_btn;

    assign io_hit  = (Bus_addr >= IO_BASE);
    assign sel_dig = (Bus_addr == A_DIG);
    assign sel_tmr = (Bus_addr == A_TMR);
    assign sel_led = (Bus_addr == A_LED);
    assign sel_sw  = (Bus_addr == A_SW);
    assign sel_btn = (Bus_addr == A_BTN);

    assign dram_addr  = Bus_addr[DRAM_AW+1:2];
    assign dram_we    = io_hit ? 4'h0 : Bus_we;
    assign dram_wdata = Bus_wdata;

    always_comb begin
        dig_d  = dig_q;
        led_d  = led_q;
        tmr_d  = tmr_q + 32'd1;
        scan_d = scan_q + SCW'(1);
        idx_d  = idx_q;
        sw1_d  = sw;
        sw2_d  = sw1_q;
        btn1_d = btn;
        btn2_d = btn1_q;
        for (int i = 0; i < 4; i++) begin
            if (sel_dig && Bus_we[i]) dig_d[8*i +: 8] = Bus_wdata[8*i +: 8];
        end
        // lane 3 has no LED bits behind it
        for (int i = 0; i < 3; i++) begin
            if (sel_led && Bus_we[i]) led_d[8*i +: 8] = Bus_wdata[8*i +: 8];
        end
        if (sel_tmr && Bus_we == 4'hF) tmr_d = Bus_wdata;
        if (scan_q == SCAN_LAST) begin
            scan_d = '0;
            idx_d  = idx_q + 3'd1;
        end
    end

    always_ff @(posedge cpu_clk or negedge cpu_rst) begin
        if (!cpu_rst) begin
            dig_q  <= '0;
            led_q  <= '0;
            tmr_q  <= '0;
            scan_q <= '0;
            idx_q  <= '0;
            sw1_q  <= '0;
            sw2_q  <= '0;
            btn1_q <= '0;
            btn2_q <= '0;
        end else begin
            dig_q  <= dig_d;
            led_q  <= led_d;
            tmr_q  <= tmr_d;
            scan_q <= scan_d;
            idx_q  <= idx_d;
            sw1_q  <= sw1_d;
            sw2_q  <= sw2_d;
            btn1_q <= btn1_d;
            btn2_q <= btn2_d;
        end
    end

    always_comb begin
        Bus_rdata = 32'h0;
        unique case (1'b1)
            !io_hit: Bus_rdata = dram_rdata;
            sel_dig: Bus_rdata = dig_q;
            sel_tmr: Bus_rdata = tmr_q;
            sel_led: Bus_rdata = {8'h00, led_q};
            sel_sw:  Bus_rdata = {8'h00, sw2_q};
            sel_btn: Bus_rdata = {27'h0, btn2_q};
            default: Bus_rdata = 32'h0;
        endcase
    end

    function automatic logic [7:0] hex7(input logic [3:0] n);
        case (n)
            4'h0:    hex7 = 8'h3F;
            4'h1:    hex7 = 8'h06;
            4'h2:    hex7 = 8'h5B;
            4'h3:    hex7 = 8'h4F;
            4'h4:    hex7 = 8'h66;
            4'h5:    hex7 = 8'h6D;
            4'h6:    hex7 = 8'h7D;
            4'h7:    hex7 = 8'h07;
            4'h8:    hex7 = 8'h7F;
            4'h9:    hex7 = 8'h6F;
            4'hA:    hex7 = 8'h77;
            4'hB:    hex7 = 8'h7C;
            4'hC:    hex7 = 8'h39;
            4'hD:    hex7 = 8'h5E;
            4'hE:    hex7 = 8'h79;
            default: hex7 = 8'h71;
        endcase
    endfunction

    assign led     = led_q;
    assign dig_en  = ~(8'b1 << idx_q);
    assign dig_seg = hex7(dig_q[{idx_q, 2'b00} +: 4]);

endmodule

// File: tb/tb_bus_bridge.sv
// Directed bench for bus_bridge: scoreboard queue of expected values,
// popped and checked with immediate assertions as the DUT responds.
module tb_bus_bridge;

    localparam int SD = 4;
    localparam logic [31:0] A_DIG = 32'hFFFF_F000;
    localparam logic [31:0] A_TMR = 32'hFFFF_F020;
    localparam logic [31:0] A_LED = 32'hFFFF_F060;
    localparam logic [31:0] A_SW  = 32'hFFFF_F070;
    localparam logic [31:0] A_BTN = 32'hFFFF_F078;
    localparam logic [31:0] A_NUL = 32'hFFFF_F040;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] addr = '0;
    logic [3:0]  we = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic [13:0] dram_addr;
    logic [3:0]  dram_we;
    logic [31:0] dram_wdata;
    logic [31:0] dram_rdata = 32'hC0FF_EE11;
    logic [23:0] sw = '0;
    logic [4:0]  btn = '0;
    logic [23:0] led;
    logic [7:0]  dig_en;
    logic [7:0]  dig_seg;

    int checks = 0;
    int errors = 0;
    string       tag_q[$];
    logic [31:0] exp_q[$];

    bus_bridge #(.SCAN_DIV(SD), .DRAM_AW(14)) dut (
        .cpu_clk(clk), .cpu_rst(rst_n),
        .Bus_addr(addr), .Bus_we(we), .Bus_wdata(wdata), .Bus_rdata(rdata),
        .dram_addr(dram_addr), .dram_we(dram_we), .dram_wdata(dram_wdata),
        .dram_rdata(dram_rdata), .sw(sw), .btn(btn),
        .led(led), .dig_en(dig_en), .dig_seg(dig_seg)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] seg_of(input logic [3:0] n);
        logic [7:0] t [16];
        t = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
              8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};
        return t[n];
    endfunction

    task automatic push(input string t, input logic [31:0] e);
        tag_q.push_back(t);
        exp_q.push_back(e);
    endtask

    task automatic chk(input logic [31:0] obs);
        string t;
        logic [31:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty obs=%h", obs);
            return;
        end
        t = tag_q.pop_front();
        e = exp_q.pop_front();
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s obs=%h exp=%h", t, obs, e);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        addr = a;
        we = 4'h0;
        #1;
        d = rdata;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
        addr = a;
        wdata = d;
        we = w;
        tick(1);
        we = 4'h0;
    endtask

    initial begin
        logic [31:0] v;
        logic [31:0] dig_val;
        logic [2:0]  ix;

        tick(2);
        rst_n = 1'b1;

        // LED byte lanes
        wr(A_LED, 32'h00AB_CDEF, 4'hF);
        push("led_full", 32'h00AB_CDEF); chk({8'h0, led});
        wr(A_LED, 32'h0012_3412, 4'b0100);
        push("led_lane2", 32'h0012_CDEF); chk({8'h0, led});
        rd(A_LED, v);
        push("led_read", 32'h0012_CDEF); chk(v);

        // DRAM routing
        addr = 32'h0000_0104; wdata = 32'hDEAD_BEEF; we = 4'hF; #1;
        push("dram_we_hit", 32'hF); chk({28'h0, dram_we});
        push("dram_addr", 32'h41); chk({18'h0, dram_addr});
        push("dram_wdata", 32'hDEAD_BEEF); chk(dram_wdata);
        push("dram_rdata", 32'hC0FF_EE11); chk(rdata);
        tick(1);
        push("led_after_dram", 32'h0012_CDEF); chk({8'h0, led});
        addr = A_LED; wdata = 32'h0012_CDEF; #1;
        push("dram_we_io", 32'h0); chk({28'h0, dram_we});
        we = 4'h0;

        // timer load, wrap, partial write
        wr(A_TMR, 32'hFFFF_FFFE, 4'hF);
        rd(A_TMR, v); push("tmr_load", 32'hFFFF_FFFE); chk(v);
        tick(1);
        rd(A_TMR, v); push("tmr_max", 32'hFFFF_FFFF); chk(v);
        tick(1);
        rd(A_TMR, v); push("tmr_wrap", 32'h0); chk(v);
        wr(A_TMR, 32'h0000_0055, 4'b0001);
        rd(A_TMR, v); push("tmr_partial", 32'h1); chk(v);

        // mid-run reset with an LED write pending
        addr = A_LED; wdata = 32'h00FF_FFFF; we = 4'hF;
        rst_n = 1'b0; #1;
        push("rst_led", 32'h0); chk({8'h0, led});
        tick(2);
        push("rst_led_held", 32'h0); chk({8'h0, led});
        push("rst_dig_en", 32'hFE); chk({24'h0, dig_en});
        push("rst_dig_seg", 32'h3F); chk({24'h0, dig_seg});
        rd(A_TMR, v); push("rst_tmr", 32'h0); chk(v);
        tick(1);
        rd(A_TMR, v); push("rst_tmr_held", 32'h0); chk(v);
        rst_n = 1'b1;
        tick(5);
        rd(A_TMR, v); push("tmr_after_rel", 32'h5); chk(v);

        // scanner, phase aligned by a fresh reset
        rst_n = 1'b0; tick(1);
        rst_n = 1'b1;
        dig_val = 32'h8765_43A1;
        wr(A_DIG, dig_val, 4'hF);
        rd(A_DIG, v); push("dig_read", dig_val); chk(v);
        for (int k = 1; k <= 33; k++) begin
            if (k > 1) tick(1);
            ix = 3'((k / SD) % 8);
            push($sformatf("scan_en_%0d", k), {24'h0, ~(8'b1 << ix)});
            chk({24'h0, dig_en});
            push($sformatf("scan_seg_%0d", k), {24'h0, seg_of(dig_val[4*ix +: 4])});
            chk({24'h0, dig_seg});
        end

        // DIG partial lane
        wr(A_DIG, 32'hFFFF_FFFF, 4'b0010);
        rd(A_DIG, v); push("dig_lane1", 32'h8765_FFA1); chk(v);

        // synchronized inputs
        sw = 24'h5A_5A5A; btn = 5'b10011;
        tick(1);
        rd(A_SW, v); push("sw_1edge", 32'h0); chk(v);
        tick(1);
        rd(A_SW, v); push("sw_2edge", 32'h005A_5A5A); chk(v);
        rd(A_BTN, v); push("btn_2edge", 32'h13); chk(v);
        wr(A_SW, 32'h0, 4'hF);
        rd(A_SW, v); push("sw_nowrite", 32'h005A_5A5A); chk(v);

        // unmapped I/O
        rd(A_NUL, v); push("nul_read", 32'h0); chk(v);
        addr = A_NUL; wdata = 32'hFFFF_FFFF; we = 4'hF; #1;
        push("nul_dram_we", 32'h0); chk({28'h0, dram_we});
        tick(1);
        we = 4'h0;
        rd(A_NUL, v); push("nul_read2", 32'h0); chk(v);
        push("nul_led", 32'h0); chk({8'h0, led});
        rd(A_DIG, v); push("nul_dig", 32'h8765_FFA1); chk(v);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
